// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl
// Pointer and flag controller for the small register-file FIFO. It produces
// the write row select and write enable for the 2-to-4 write-select
// decoder, and the read row select for the output mux. It also tracks
// occupancy (count, full, empty) and holds sticky overflow/underflow flags.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   wr_req     write request from producer
//   rd_req     read request from consumer
//   wr_addr    write row select (decoder data_in), register output
//   wr_en      qualified write (decoder enable), combinational
//   rd_addr    read row select to output mux, register output
//   rd_en      qualified read, data valid at rd_addr this cycle
//   full       FIFO holds DEPTH entries (registered)
//   empty      FIFO holds 0 entries (registered)
//   count      occupancy, 0..DEPTH
//   overflow   sticky: write requested while full
//   underflow  sticky: read requested while empty
//
// Handshake: wr_req/rd_req are requests and ~full/~empty act as ready.
// A transfer happens only in a cycle where request and ready are both high
// (wr_en / rd_en). A request without ready is dropped, not held, and it
// sets the matching sticky error flag at the next edge.
//
// Occupancy states are EMPTY -> PARTIAL -> FULL. They follow directly from
// count, so the full/empty flags carry that state. There is no separate
// state register.

module fifo_ptr_ctrl #(
  parameter  int ADDR_W = 2,
  localparam int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              rd_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  // The pointers carry one extra wrap bit. When the addresses are equal,
  // the wrap bit tells full (bits differ) apart from empty (bits equal).
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] wr_ptr_nxt;
  logic [ADDR_W:0] rd_ptr_nxt;
  logic [ADDR_W:0] count_nxt;
  logic            full_nxt;
  logic            empty_nxt;

  // Gating uses the registered flags only. This blocks a write into a full
  // FIFO even when a read happens in the same cycle, and it blocks a read
  // of data written in the same cycle.
  assign wr_en = wr_req & ~full;
  assign rd_en = rd_req & ~empty;

  assign wr_addr = wr_ptr[ADDR_W-1:0];
  assign rd_addr = rd_ptr[ADDR_W-1:0];

  always_comb begin
    wr_ptr_nxt = wr_ptr + {{ADDR_W{1'b0}}, wr_en};
    rd_ptr_nxt = rd_ptr + {{ADDR_W{1'b0}}, rd_en};
    count_nxt  = count + {{ADDR_W{1'b0}}, wr_en} - {{ADDR_W{1'b0}}, rd_en};
    full_nxt   = (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]) &&
                 (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]);
    empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
  end

  // Reset has priority over any request in the same cycle. It discards
  // all contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      full      <= full_nxt;
      empty     <= empty_nxt;
      overflow  <= overflow | (wr_req & full);
      underflow <= underflow | (rd_req & empty);
    end
  end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Testbench for fifo_ptr_ctrl.
// The driver applies directed vectors on the falling edge and pushes the
// hand-computed outputs for that cycle into exp_q. A separate monitor pops
// one entry per presented vector, 2 time units after the falling edge, and
// compares it with the packed DUT outputs.
// Packed layout: {wr_en, rd_en, wr_addr[1:0], rd_addr[1:0], full, empty,
//                 count[2:0], overflow, underflow}

module tb_fifo_ptr_ctrl;

  localparam int W = 13;

  logic       clk;
  logic       rst;
  logic       wr_req;
  logic       rd_req;
  logic [1:0] wr_addr;
  logic       wr_en;
  logic [1:0] rd_addr;
  logic       rd_en;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_vec;
  int           n_miss;

  fifo_ptr_ctrl #(.ADDR_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (wr_req),
    .rd_req    (rd_req),
    .wr_addr   (wr_addr),
    .wr_en     (wr_en),
    .rd_addr   (rd_addr),
    .rd_en     (rd_en),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: apply inputs for one cycle and queue the expected outputs.
  task automatic step(input logic r, input logic w, input logic rd,
                      input string nm,
                      input logic e_we, input logic e_re,
                      input logic [1:0] e_wa, input logic [1:0] e_ra,
                      input logic e_f, input logic e_e, input logic [2:0] e_c,
                      input logic e_ov, input logic e_un);
    rst    = r;
    wr_req = w;
    rd_req = rd;
    exp_q.push_back({e_we, e_re, e_wa, e_ra, e_f, e_e, e_c, e_ov, e_un});
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    logic [W-1:0] act;
    logic [W-1:0] exp_v;
    string        nm;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        act   = {wr_en, rd_en, wr_addr, rd_addr, full, empty, count,
                 overflow, underflow};
        n_vec++;
        if (act !== exp_v) begin
          n_miss++;
          $display("FAIL %s: got we%b re%b wa%0d ra%0d f%b e%b c%0d ov%b un%b, required we%b re%b wa%0d ra%0d f%b e%b c%0d ov%b un%b",
                   nm, act[12], act[11], act[10:9], act[8:7], act[6], act[5],
                   act[4:2], act[1], act[0],
                   exp_v[12], exp_v[11], exp_v[10:9], exp_v[8:7], exp_v[6],
                   exp_v[5], exp_v[4:2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (2) @(negedge clk);

    //   rst wr rd  name           we re wa ra  f  e  c  ov un
    step(0, 0, 0, "reset_idle",    0, 0, 0, 0,  0, 1, 0, 0, 0);
    // Fill
    step(0, 1, 0, "fill0",         1, 0, 0, 0,  0, 1, 0, 0, 0);
    step(0, 1, 0, "fill1",         1, 0, 1, 0,  0, 0, 1, 0, 0);
    step(0, 1, 0, "fill2",         1, 0, 2, 0,  0, 0, 2, 0, 0);
    step(0, 1, 0, "fill3",         1, 0, 3, 0,  0, 0, 3, 0, 0);
    step(0, 1, 0, "wr_when_full",  0, 0, 0, 0,  1, 0, 4, 0, 0);
    step(0, 0, 0, "overflow_set",  0, 0, 0, 0,  1, 0, 4, 1, 0);
    // Drain
    step(0, 0, 1, "drain0",        0, 1, 0, 0,  1, 0, 4, 1, 0);
    step(0, 0, 1, "drain1",        0, 1, 0, 1,  0, 0, 3, 1, 0);
    step(0, 0, 1, "drain2",        0, 1, 0, 2,  0, 0, 2, 1, 0);
    step(0, 0, 1, "drain3",        0, 1, 0, 3,  0, 0, 1, 1, 0);
    step(0, 0, 1, "rd_when_empty", 0, 0, 0, 0,  0, 1, 0, 1, 0);
    step(0, 0, 0, "underflow_set", 0, 0, 0, 0,  0, 1, 0, 1, 1);
    // Bring count to 2, then simultaneous read+write across the wrap
    step(0, 1, 0, "pre_sim0",      1, 0, 0, 0,  0, 1, 0, 1, 1);
    step(0, 1, 0, "pre_sim1",      1, 0, 1, 0,  0, 0, 1, 1, 1);
    step(0, 1, 1, "sim0",          1, 1, 2, 0,  0, 0, 2, 1, 1);
    step(0, 1, 1, "sim1",          1, 1, 3, 1,  0, 0, 2, 1, 1);
    step(0, 1, 1, "sim2",          1, 1, 0, 2,  0, 0, 2, 1, 1);
    step(0, 0, 0, "sim_after",     0, 0, 1, 3,  0, 0, 2, 1, 1);
    // Refill to 4 with wrapped pointers, then read+write while full
    step(0, 1, 0, "refill0",       1, 0, 1, 3,  0, 0, 2, 1, 1);
    step(0, 1, 0, "refill1",       1, 0, 2, 3,  0, 0, 3, 1, 1);
    step(0, 1, 1, "full_rw",       0, 1, 3, 3,  1, 0, 4, 1, 1);
    step(0, 0, 0, "full_rw_after", 0, 0, 3, 0,  0, 0, 3, 1, 1);
    // Reset while a write is requested at count=3
    step(1, 1, 0, "rst_mid_fill",  1, 0, 3, 0,  0, 0, 3, 1, 1);
    step(0, 0, 0, "after_rst",     0, 0, 0, 0,  0, 1, 0, 0, 0);
    // Fresh fill, then read+write while full sets overflow from clean state
    step(0, 1, 0, "fill_b0",       1, 0, 0, 0,  0, 1, 0, 0, 0);
    step(0, 1, 0, "fill_b1",       1, 0, 1, 0,  0, 0, 1, 0, 0);
    step(0, 1, 0, "fill_b2",       1, 0, 2, 0,  0, 0, 2, 0, 0);
    step(0, 1, 0, "fill_b3",       1, 0, 3, 0,  0, 0, 3, 0, 0);
    step(0, 1, 1, "full_rw_b",     0, 1, 0, 0,  1, 0, 4, 0, 0);
    step(0, 0, 0, "full_rw_b_aft", 0, 0, 0, 1,  0, 0, 3, 1, 0);
    // Reset, then read+write while empty: write lands, read is refused
    step(1, 0, 0, "rst_again",     0, 0, 0, 1,  0, 0, 3, 1, 0);
    step(0, 1, 1, "empty_rw",      1, 0, 0, 0,  0, 1, 0, 0, 0);
    step(0, 0, 0, "empty_rw_aft",  0, 0, 1, 0,  0, 0, 1, 0, 1);
    step(0, 0, 1, "read_latency",  0, 1, 1, 0,  0, 0, 1, 0, 1);
    step(0, 0, 0, "final_idle",    0, 0, 1, 1,  0, 1, 0, 0, 1);

    // Bounded drain of the scoreboard
    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain_timeout: got %0d entries left, required 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
